// File: rtl/iobuf_seq_pkg.sv
// iobuf_seq_pkg
// Definitions shared by the serial IOBUF sequencer and its sub-module.
//   state_t  : sequencer state encoding (IDLE, DRIVE, TURN, SAMPLE, RESP)
//   MAX_BITS : largest number of bits a single command can move
//   LEN_W    : width of the cmd_len field (bit count minus one)
`timescale 1ns/1ps

package iobuf_seq_pkg;

    localparam int MAX_BITS = 32;
    localparam int LEN_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_TURN   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/iobuf_seq_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer that brings the asynchronous pad value into the clk
// domain. Both flops clear to 0 on reset.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of latency)
`timescale 1ns/1ps

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs at the same edge and form a true two-stage chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/iobuf_seq.sv
// iobuf_seq
// Command-driven serial sequencer for a bidirectional pad behind an IOBUF.
// A write drives up to 32 bits onto the pad (MSB of the field first), then
// tristates for TURN_CYC cycles. A read samples up to 32 bits from the
// synchronized pad value. Every command ends with a response handshake.
// Parameters:
//   CLK_DIV  : clk cycles per serial bit period (2..256)
//   TURN_CYC : tristated turnaround cycles after a drive phase (1..15)
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_write            : 1 = drive, 0 = sample
//   cmd_len              : bit count minus one
//   cmd_wdata            : write bits, right-justified
//   rsp_valid/rsp_ready  : response handshake
//   rsp_rdata            : sampled bits, right-justified, first bit highest
//   pin_i, pin_t, pin_o  : IOBUF I (drive value), T (1 = tristate), O (pad)
//   busy                 : high whenever not IDLE
`timescale 1ns/1ps

module iobuf_seq
    import iobuf_seq_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int TURN_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_rdata,
    output logic                pin_i,
    output logic                pin_t,
    input  logic                pin_o,
    output logic                busy
);

    localparam int PER_W  = (CLK_DIV > 2)  ? $clog2(CLK_DIV)  : 1;
    localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [PER_W-1:0]  PER_LAST   = PER_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0]  SAMPLE_OFF = PER_W'(CLK_DIV / 2);
    localparam logic [TURN_W-1:0] TURN_LAST  = TURN_W'(TURN_CYC - 1);

    state_t state, state_next;

    logic [LEN_W-1:0]    len_q;
    logic [PER_W-1:0]    per_cnt;
    logic [LEN_W-1:0]    bit_cnt;
    logic [TURN_W-1:0]   turn_cnt;
    logic [MAX_BITS-1:0] shreg;    // write bits, current bit kept in the MSB
    logic [MAX_BITS-1:0] rdata_q;
    logic                pin_sync;

    logic accept, per_last, bit_last, turn_last;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_o),
        .q   (pin_sync)
    );

    assign accept    = cmd_valid && (state == ST_IDLE);
    assign per_last  = (per_cnt == PER_LAST);
    assign bit_last  = (bit_cnt == len_q);
    assign turn_last = (turn_cnt == TURN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // pin_t is decoded straight from the async-reset state register, so an
    // asserted rst releases the pad without waiting for a clock edge.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        pin_t      = 1'b1;
        pin_i      = 1'b0;
        busy       = 1'b1;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_next = cmd_write ? ST_DRIVE : ST_SAMPLE;
            end
            ST_DRIVE: begin
                pin_t = 1'b0;
                pin_i = shreg[MAX_BITS-1];
                if (per_last && bit_last) state_next = ST_TURN;
            end
            ST_TURN: begin
                if (turn_last) state_next = ST_RESP;
            end
            ST_SAMPLE: begin
                if (per_last && bit_last) state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            per_cnt  <= '0;
            bit_cnt  <= '0;
            turn_cnt <= '0;
            shreg    <= '0;
            rdata_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        len_q    <= cmd_len;
                        per_cnt  <= '0;
                        bit_cnt  <= '0;
                        turn_cnt <= '0;
                        rdata_q  <= '0;
                        // Left-justify the field so the first bit to send is the MSB.
                        shreg    <= cmd_write
                                    ? (cmd_wdata << (LEN_W'(MAX_BITS - 1) - cmd_len))
                                    : '0;
                    end
                end
                ST_DRIVE: begin
                    per_cnt <= per_last ? '0 : per_cnt + PER_W'(1);
                    if (per_last) begin
                        bit_cnt <= bit_last ? '0 : bit_cnt + LEN_W'(1);
                        shreg   <= shreg << 1;
                    end
                end
                ST_TURN: begin
                    turn_cnt <= turn_last ? '0 : turn_cnt + TURN_W'(1);
                end
                ST_SAMPLE: begin
                    per_cnt <= per_last ? '0 : per_cnt + PER_W'(1);
                    // Shifting in at the LSB leaves the first bit at position len.
                    if (per_cnt == SAMPLE_OFF) rdata_q <= {rdata_q[MAX_BITS-2:0], pin_sync};
                    if (per_last) bit_cnt <= bit_last ? '0 : bit_cnt + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_iobuf_seq.sv
// tb_iobuf_seq
// Self-checking bench for iobuf_seq (CLK_DIV = 4, TURN_CYC = 2). Expected pad
// waveforms and read data are computed from the command fields and the pad
// bit sequence; outputs are sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_iobuf_seq;

    localparam int CLK_DIV  = 4;
    localparam int TURN_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        pin_i;
    logic        pin_t;
    logic        pin_o;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iobuf_seq #(
        .CLK_DIV  (CLK_DIV),
        .TURN_CYC (TURN_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .pin_i     (pin_i),
        .pin_t     (pin_t),
        .pin_o     (pin_o),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Optionally stall the response, pulsing cmd_valid meanwhile, then complete it.
    task automatic finish_rsp(input int hold, input logic [31:0] expd);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, expd);
            check("hold_ready", cmd_ready, 0);
            cmd_valid = (i % 2 == 1);
            cmd_write = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done_valid", rsp_valid, 0);
        check("rsp_done_ready", cmd_ready, 1);
        check("rsp_done_busy", busy, 0);
    endtask

    task automatic run_write(input logic [4:0] len, input logic [31:0] wd);
        int nb;
        int idx;
        nb = int'(len) + 1;
        @(negedge clk);
        check("wr_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_len   = len;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < nb * CLK_DIV; c++) begin
            idx = nb - 1 - c / CLK_DIV;
            check("drive_pin_t", pin_t, 0);
            check("drive_pin_i", pin_i, wd[idx]);
            @(negedge clk);
        end
        for (int c = 0; c < TURN_CYC; c++) begin
            check("turn_pin_t", pin_t, 1);
            check("turn_pin_i", pin_i, 0);
            check("turn_rsp_valid", rsp_valid, 0);
            @(negedge clk);
        end
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_rdata", rsp_rdata, 0);
        finish_rsp(0, 32'h0);
    endtask

    // seq[k] is the pad value during bit period k (time order).
    task automatic run_read(input logic [4:0] len, input logic [31:0] seq, input int hold);
        int nb;
        int cyc;
        logic [31:0] exp;
        nb  = int'(len) + 1;
        exp = '0;
        for (int k = 0; k < nb; k++) exp[nb - 1 - k] = seq[k];
        @(negedge clk);
        check("rd_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_len   = len;
        cmd_wdata = $urandom;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < nb * CLK_DIV + 20) begin
            if (cyc % CLK_DIV == 0 && cyc / CLK_DIV < nb) pin_o = seq[cyc / CLK_DIV];
            check("sample_pin_t", pin_t, 1);
            cyc++;
            @(negedge clk);
        end
        check("rd_sample_cycles", cyc, nb * CLK_DIV);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, exp);
        finish_rsp(hold, exp);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_len   = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        pin_o     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pin_t", pin_t, 1);
        check("rst_pin_i", pin_i, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;

        // 8-bit write of 0xA5
        run_write(5'd7, 32'h0000_00A5);

        // 4-bit read, pad 1,1,0,1 -> 0xD
        run_read(5'd3, 32'h0000_000B, 0);

        // 32-bit read, pad alternating starting with 1 -> 0xAAAAAAAA
        run_read(5'd31, 32'h5555_5555, 0);

        // Response stalled 10 cycles with cmd_valid pulses in between
        run_read(5'd5, 32'h0000_0029, 10);

        // Reset in bit 3 of an 8-bit write
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_len   = 5'd7;
        cmd_wdata = 32'h0000_00FF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3 * CLK_DIV + 1) @(negedge clk);
        check("mid_pin_t", pin_t, 0);
        rst = 1'b1;
        #1;
        check("async_rst_pin_t", pin_t, 1);
        check("async_rst_pin_i", pin_i, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_rsp_valid", rsp_valid, 0);
        repeat (3) @(negedge clk);
        check("post_rst_no_rsp", rsp_valid, 0);
        check("post_rst_idle", busy, 0);
        run_write(5'd7, 32'h0000_003C);

        // 1-bit write followed by a read with cmd_valid held throughout
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_len   = 5'd0;
        cmd_wdata = 32'h0000_0001;
        rsp_ready = 1'b1;
        pin_o     = 1'b1;
        @(negedge clk);
        cmd_write = 1'b0;
        cmd_len   = 5'd1;
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b_first_latency", cyc, CLK_DIV + TURN_CYC);
        check("b2b_first_rdata", rsp_rdata, 0);
        @(negedge clk);
        check("b2b_idle_ready", cmd_ready, 1);
        check("b2b_idle_busy", busy, 0);
        @(negedge clk);
        check("b2b_second_accepted", busy, 1);
        check("b2b_second_pin_t", pin_t, 1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b_second_rdata", rsp_rdata, 32'h0000_0003);
        finish_rsp(0, 32'h0000_0003);

        // Randomized commands
        for (int n = 0; n < 12; n++) begin
            logic [4:0]  len;
            logic [31:0] data;
            len  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            data = $urandom;
            if ($urandom_range(0, 1) == 1) run_write(len, data);
            else                           run_read(len, data, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
